// File: rtl/uart_fifo_ctrl.sv
// UART TX/RX character buffers between the APB register block and the TSR/RSR shifters.
// Supports FIFO mode or a one-entry holding register, RX error tagging, trigger level, overrun and timeout.
module uart_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TO_CHARS   = 4
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic                          fifoen,
    input  logic                          txclr,
    input  logic                          rxclr,
    input  logic [1:0]                    txfiftl,
    input  logic [1:0]                    rxfiftl,
    input  logic                          tx_wr_en,
    input  logic [DATA_WIDTH-1:0]         tx_wdata,
    input  logic                          tsr_load,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_empty,
    output logic                          tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          tx_req,
    input  logic                          rx_done,
    input  logic [DATA_WIDTH-1:0]         rx_wdata,
    input  logic [2:0]                    rx_err,
    input  logic                          rbr_rd_en,
    input  logic                          lsr_rd_en,
    input  logic                          char_tick,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic [2:0]                    rx_head_err,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_trig,
    output logic                          rx_overrun,
    output logic                          rx_fifo_err,
    output logic                          rx_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] TO_LVL = 3'(TO_CHARS);

    logic [DATA_WIDTH-1:0] tx_mem  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem  [FIFO_DEPTH];
    logic [2:0]            rx_emem [FIFO_DEPTH];

    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic          ovr_q, ovr_d;
    logic [2:0]    to_cnt_q, to_cnt_d;
    logic          to_q, to_d;
    logic          fifoen_q;

    logic [CW-1:0] cap;
    logic [CW-1:0] rx_lvl, tx_lvl;
    logic          mode_chg, tx_clr, rx_clr;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    assign mode_chg = fifoen_q != fifoen;
    assign tx_clr   = txclr | mode_chg;
    assign rx_clr   = rxclr | mode_chg;
    assign cap      = fifoen ? CW'(FIFO_DEPTH) : CW'(1);

    assign tx_empty = tx_cnt_q == '0;
    assign tx_full  = tx_cnt_q >= cap;
    assign rx_empty = rx_cnt_q == '0;
    assign rx_full  = rx_cnt_q >= cap;

    // A pop frees the slot in the same edge, so a full FIFO still accepts a push alongside a pop.
    assign tx_pop  = tsr_load & ~tx_empty;
    assign tx_push = tx_wr_en & (~tx_full | tx_pop);
    assign rx_pop  = rbr_rd_en & ~rx_empty;
    assign rx_push = rx_done & (~rx_full | rx_pop);

    assign tx_data     = tx_empty ? '0 : tx_mem[tx_rp_q];
    assign rx_data     = rx_empty ? '0 : rx_mem[rx_rp_q];
    assign rx_head_err = rx_empty ? '0 : rx_emem[rx_rp_q];

    always_comb begin
        case (rxfiftl)
            2'd0:    rx_lvl = CW'(1);
            2'd1:    rx_lvl = CW'(FIFO_DEPTH / 4);
            2'd2:    rx_lvl = CW'(FIFO_DEPTH / 2);
            default: rx_lvl = CW'(FIFO_DEPTH - 2);
        endcase
        case (txfiftl)
            2'd0:    tx_lvl = '0;
            2'd1:    tx_lvl = CW'(FIFO_DEPTH / 4);
            2'd2:    tx_lvl = CW'(FIFO_DEPTH / 2);
            default: tx_lvl = CW'(3 * FIFO_DEPTH / 4);
        endcase
    end

    assign tx_count    = tx_cnt_q;
    assign rx_count    = rx_cnt_q;
    assign tx_req      = fifoen ? (tx_cnt_q <= tx_lvl) : tx_empty;
    assign rx_trig     = fifoen ? (rx_cnt_q >= rx_lvl) : ~rx_empty;
    assign rx_overrun  = ovr_q;
    assign rx_fifo_err = (err_cnt_q != '0) & fifoen;
    assign rx_timeout  = to_q;

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_clr) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
            if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
            tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        end
    end

    always_comb begin
        rx_wp_d   = rx_wp_q;
        rx_rp_d   = rx_rp_q;
        rx_cnt_d  = rx_cnt_q;
        err_cnt_d = err_cnt_q;
        ovr_d     = ovr_q;
        to_cnt_d  = to_cnt_q;
        if (rx_clr) begin
            rx_wp_d   = '0;
            rx_rp_d   = '0;
            rx_cnt_d  = '0;
            err_cnt_d = '0;
            ovr_d     = 1'b0;
            to_cnt_d  = '0;
        end else begin
            if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
            if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);
            rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
            err_cnt_d = err_cnt_q + CW'(rx_push & (rx_err != '0))
                                  - CW'(rx_pop & (rx_head_err != '0));
            // A new overrun outranks the LSR read that would clear it.
            if (rx_done & ~rx_push)
                ovr_d = 1'b1;
            else if (lsr_rd_en)
                ovr_d = 1'b0;
            if (rx_push | rx_pop | rx_empty)
                to_cnt_d = '0;
            else if (char_tick && to_cnt_q != 3'd7)
                to_cnt_d = to_cnt_q + 3'd1;
        end
        to_d = fifoen & (rx_cnt_d != '0) & (to_cnt_d >= TO_LVL);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
            ovr_q     <= 1'b0;
            to_cnt_q  <= '0;
            to_q      <= 1'b0;
            fifoen_q  <= 1'b0;
        end else begin
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            rx_cnt_q  <= rx_cnt_d;
            err_cnt_q <= err_cnt_d;
            ovr_q     <= ovr_d;
            to_cnt_q  <= to_cnt_d;
            to_q      <= to_d;
            fifoen_q  <= fifoen;
        end
    end

    // Character storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge pclk) begin
        if (tx_push & ~tx_clr)
            tx_mem[tx_wp_q] <= tx_wdata;
        if (rx_push & ~rx_clr) begin
            rx_mem[rx_wp_q]  <= rx_wdata;
            rx_emem[rx_wp_q] <= rx_err;
        end
    end

endmodule
